fft_frame_source: RTL and testbench

- Transmit-side framer that feeds the xfft core: converts the free-running ADC sample strobe (no backpressure) into AXI-Stream frames of exactly 2^NFFT_LOG2 samples, with tlast on the final sample.
- Also acts as master on the FFT config channel, issuing the transform-setup word after reset and on request.
- Sits in the clk_245 domain between the FMC150 ADC capture path and the FFT slave data/config ports.
- Buffers samples in a small FIFO to absorb FFT tready stalls.

---
 rtl/fft_frame_source_if.sv | 33 +++
 rtl/fft_frame_source.sv | 143 ++++++++++++++
 tb/tb_fft_frame_source.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_source_if.sv
// Stream bundle between the frame source and the xfft core: the sample data
// channel plus the transform configuration channel.
interface fft_frame_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  logic [23:0]           m_axis_config_tdata;
  logic                  m_axis_config_tvalid;
  logic                  m_axis_config_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready,
    output m_axis_config_tdata,
    output m_axis_config_tvalid,
    input  m_axis_config_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready,
    input  m_axis_config_tdata,
    input  m_axis_config_tvalid,
    output m_axis_config_tready
  );
endinterface

// File: rtl/fft_frame_source.sv
// Frame source for the xfft core. The free-running ADC strobe is cut into
// frames of 2^NFFT_LOG2 samples (tlast on the final one), buffered in a small
// first-word-fall-through FIFO so FFT stalls only cost dropped samples, never
// a short frame. The config word is sent after reset and on request.
module fft_frame_source #(
  parameter int         DATA_WIDTH      = 32,
  parameter int         NFFT_LOG2       = 13,
  parameter int         FIFO_DEPTH_LOG2 = 4,
  parameter int         FWD_INV         = 1,
  parameter logic [5:0] SCALE_SCH       = 6'b0
) (
  input  logic                  clk_245,
  input  logic                  clk_245_rst,
  input  logic [DATA_WIDTH-1:0] adc_tdata,
  input  logic                  adc_tvalid,
  input  logic                  arm,
  input  logic                  cfg_update,
  fft_frame_source_if.master    fft,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam logic [23:0] CFG_WORD = {9'b0, SCALE_SCH, 1'(FWD_INV), 3'b0, 5'(NFFT_LOG2)};

  typedef enum logic [1:0] {CFG, IDLE, CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [NFFT_LOG2-1:0]   cnt_q, cnt_d;
  logic                   cfg_pend_q, cfg_pend_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH:0]    mem_q [DEPTH];

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   wr_en;
  logic                   rd_en;
  logic                   sample_last;
  logic [DATA_WIDTH:0]    head;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign sample_last = (cnt_q == {NFFT_LOG2{1'b1}});
  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_en       = !fifo_empty && fft.m_axis_tready;

  // Output side: FIFO head is presented directly; zeros whenever nothing is queued.
  always_comb begin
    fft.m_axis_tvalid        = !fifo_empty;
    fft.m_axis_tdata         = '0;
    fft.m_axis_tlast         = 1'b0;
    if (!fifo_empty) begin
      fft.m_axis_tdata = head[DATA_WIDTH-1:0];
      fft.m_axis_tlast = head[DATA_WIDTH];
    end
    fft.m_axis_config_tdata  = CFG_WORD;
    fft.m_axis_config_tvalid = (state_q == CFG) && !clk_245_rst;
    busy                     = ((state_q != IDLE) || !fifo_empty) && !clk_245_rst;
    overflow                 = overflow_q;
    frame_count              = frame_count_q;
  end

  // Framing FSM: config handshake, arming, sample counting and overflow detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_pend_d = cfg_pend_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    unique case (state_q)
      CFG: begin
        if (cfg_update) cfg_pend_d = 1'b1;
        if (fft.m_axis_config_tready) state_d = IDLE;
      end
      IDLE: begin
        if (cfg_update || cfg_pend_q) begin
          state_d    = CFG;
          cfg_pend_d = 1'b0;
        end else if (arm) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (cfg_update) cfg_pend_d = 1'b1;
        if (adc_tvalid) begin
          if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (sample_last) state_d = IDLE;
          end
        end
      end
      default: state_d = CFG;
    endcase
  end

  // Pointer and frame counter next values follow the write/read strobes.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_count_d = frame_count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (head[DATA_WIDTH]) frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Control registers; reset flushes the FIFO by clearing both pointers.
  always_ff @(posedge clk_245) begin
    if (clk_245_rst) begin
      state_q       <= CFG;
      cnt_q         <= '0;
      cfg_pend_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_pend_q    <= cfg_pend_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage carries the last flag alongside each sample.
  always_ff @(posedge clk_245) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {sample_last, adc_tdata};
  end

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed bench for fft_frame_source with 16-sample frames and a 4-entry FIFO.
module tb_fft_frame_source;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adc_tdata;
  logic        adc_tvalid;
  logic        arm;
  logic        cfg_update;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int cfg_hs = 0;
  int hs0;

  logic [32:0] beat_q [$];
  logic [32:0] exp_q  [$];
  logic        stall_prev = 1'b0;
  logic [32:0] stall_word = '0;

  fft_frame_source_if #(.DATA_WIDTH(DW)) dut_if ();

  fft_frame_source #(
    .DATA_WIDTH(DW), .NFFT_LOG2(4), .FIFO_DEPTH_LOG2(2), .FWD_INV(1), .SCALE_SCH(6'b0)
  ) dut (
    .clk_245(clk), .clk_245_rst(rst), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
    .arm(arm), .cfg_update(cfg_update), .fft(dut_if), .busy(busy),
    .overflow(overflow), .frame_count(frame_count)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (stall_prev) begin
      checkOutput("stall_tvalid", 64'(dut_if.m_axis_tvalid), 64'd1);
      checkOutput("stall_hold", 64'({dut_if.m_axis_tlast, dut_if.m_axis_tdata}), 64'(stall_word));
    end
    stall_prev = dut_if.m_axis_tvalid && !dut_if.m_axis_tready;
    stall_word = {dut_if.m_axis_tlast, dut_if.m_axis_tdata};
    if (dut_if.m_axis_tvalid && dut_if.m_axis_tready)
      beat_q.push_back({dut_if.m_axis_tlast, dut_if.m_axis_tdata});
    if (dut_if.m_axis_config_tvalid && dut_if.m_axis_config_tready) cfg_hs++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic a,
                               input logic u, input logic r);
    adc_tvalid           = v;
    adc_tdata            = d;
    arm                  = a;
    cfg_update           = u;
    dut_if.m_axis_tready = r;
    tick();
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_beats"}, 64'(beat_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_q[i]));
    beat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst                         = 1'b1;
    dut_if.m_axis_config_tready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    checkOutput("rst_cfg_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_tvalid", 64'(dut_if.m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(dut_if.m_axis_tdata), 64'd0);
    checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);

    // Config word after reset release
    rst = 1'b0;
    #1;
    checkOutput("rel_cfg_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd1);
    checkOutput("rel_busy", 64'(busy), 64'd1);
    checkOutput("cfg_tdata", 64'(dut_if.m_axis_config_tdata), 64'h000104);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("cfg_wait_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd1);
    checkOutput("cfg_wait_hs", 64'(cfg_hs), 64'd0);
    dut_if.m_axis_config_tready = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("cfg_drop_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("cfg_single_hs", 64'(cfg_hs), 64'd1);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // Clean frame, tready held high
    $display("[TB] clean frame");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b1);
    checkOutput("f1_head_data", 64'(dut_if.m_axis_tdata), 64'd15);
    checkOutput("f1_head_last", 64'(dut_if.m_axis_tlast), 64'd1);
    checkOutput("f1_busy_tail", 64'(busy), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("f1_busy_done", 64'(busy), 64'd0);
    checkOutput("f1_tvalid_done", 64'(dut_if.m_axis_tvalid), 64'd0);
    checkOutput("f1_frame_count", 64'(frame_count), 64'd1);
    checkOutput("f1_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, 32'(i)});
    checkFrame("f1");

    // Stalled frame: four accepted, six dropped, then resume
    $display("[TB] overflow frame");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("f2_overflow", 64'(overflow), 64'd1);
    checkOutput("f2_head", 64'(dut_if.m_axis_tdata), 64'hA000);
    checkOutput("f2_frame_count_mid", 64'(frame_count), 64'd1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 10; i < 22; i++) applyStimulus(1'b1, 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'hA000 + 32'(i)});
    for (int i = 10; i < 22; i++) exp_q.push_back({i == 21, 32'hA000 + 32'(i)});
    checkFrame("f2");
    checkOutput("f2_frame_count", 64'(frame_count), 64'd2);
    checkOutput("f2_overflow_sticky", 64'(overflow), 64'd1);

    // tready toggling every cycle
    $display("[TB] toggling tready frame");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 32; c++)
      applyStimulus(c % 2 == 0, 32'hB000 + 32'(c / 2), 1'b0, 1'b0, c % 2 == 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, 32'hB000 + 32'(i)});
    checkFrame("f3");
    checkOutput("f3_frame_count", 64'(frame_count), 64'd3);

    // cfg_update and a second arm during capture
    $display("[TB] config request mid-frame");
    hs0 = cfg_hs;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'hC000 + 32'(i), i == 6, i == 5, 1'b1);
    checkOutput("f4_cfg_quiet", 64'(dut_if.m_axis_config_tvalid), 64'd0);
    checkOutput("f4_cfg_hs_quiet", 64'(cfg_hs), 64'(hs0));
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("f4_cfg_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd1);
    checkOutput("f4_cfg_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("f4_cfg_hs", 64'(cfg_hs), 64'(hs0 + 1));
    checkOutput("f4_cfg_done", 64'(dut_if.m_axis_config_tvalid), 64'd0);
    checkOutput("f4_idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hFFFF, 1'b0, 1'b0, 1'b1);
    checkOutput("f4_arm_not_queued", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, 32'hC000 + 32'(i)});
    checkFrame("f4");
    checkOutput("f4_frame_count", 64'(frame_count), 64'd4);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'hD000 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("f5_pre_tvalid", 64'(dut_if.m_axis_tvalid), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    stall_prev = 1'b0;
    checkOutput("f5_rst_tvalid", 64'(dut_if.m_axis_tvalid), 64'd0);
    checkOutput("f5_rst_tdata", 64'({dut_if.m_axis_tlast, dut_if.m_axis_tdata}), 64'd0);
    checkOutput("f5_rst_frame_count", 64'(frame_count), 64'd0);
    checkOutput("f5_rst_overflow", 64'(overflow), 64'd0);
    checkOutput("f5_rst_busy", 64'(busy), 64'd0);
    checkOutput("f5_rst_cfg_tvalid", 64'(dut_if.m_axis_config_tvalid), 64'd0);
    beat_q.delete();
    rst = 1'b0;
    #1;
    checkOutput("f5_cfg_resent", 64'(dut_if.m_axis_config_tvalid), 64'd1);
    hs0 = cfg_hs;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("f5_cfg_hs", 64'(cfg_hs), 64'(hs0 + 1));
    checkOutput("f5_idle_busy", 64'(busy), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hE000 + 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, 32'hE000 + 32'(i)});
    checkFrame("f5");
    checkOutput("f5_frame_count", 64'(frame_count), 64'd1);
    checkOutput("f5_overflow", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
